prog_loader_ctrl: RTL and testbench
===================================

Name: prog_loader_ctrl

Overview:
UART boot-loader controller for the user-project instruction memory. It receives 8N1 bytes on the serial programming pin and packs them into little-endian 32-bit words. Each word is written to consecutive IMEM addresses. On an end-marker word it hands the IMEM port to the core and releases core reset. It owns the IMEM port arbitration between loader and core fetch.

Parameters:
ADDR_W, 8, IMEM word-address width (depth = 2**ADDR_W)
END_WORD, 32'h0000_0FFF, end-of-program marker word; never written to IMEM
DIV_W, 16, width of the UART clocks-per-bit divisor

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
rx_i  in  1  UART serial input, idle high; 2-flop synchronised internally
clks_per_bit_i  in  DIV_W  baud divisor; legal values are 4 or more; sampled at each start-bit detect
core_req_i  in  1  core fetch request
core_addr_i  in  ADDR_W  core fetch word address
core_gnt_o  out  1  fetch granted (combinational)
core_rdata_o  out  32  fetch data (passthrough of imem_rdata_i)
imem_csb_o  out  1  IMEM chip select, active low
imem_we_o  out  1  IMEM write enable
imem_addr_o  out  ADDR_W  IMEM address
imem_wdata_o  out  32  IMEM write data
imem_rdata_i  in  32  IMEM read data
core_rst_no  out  1  core reset, active low
done_o  out  1  load complete (sticky)
ovf_err_o  out  1  sticky: address overflow
frame_err_o  out  1  sticky: stop bit sampled low

Behaviour:
- Reset values: all outputs 0 except imem_csb_o=1. This includes core_rst_no=0, done_o=0, both error flags 0. Internal word address, byte count and shift register are cleared.
- UART receive path:
  - A falling edge on the synchronised rx starts a bit counter at clks_per_bit/2.
  - Start bit is re-checked at mid-bit. If it reads 1, the frame is discarded and the receiver returns to idle.
  - 8 data bits are sampled LSB first, one every clks_per_bit cycles. The stop bit is sampled the same way.
  - Stop=1: a 1-cycle byte_valid pulse is issued.
  - Stop=0: the byte is dropped and frame_err_o is set.
- Controller FSM:
  - IDLE: on the first byte_valid, go to COLLECT.
  - COLLECT: byte n (0..3) goes to word[8n+7:8n]. When the 4th byte arrives, go to CHECK.
  - CHECK (1 cycle):
    - word==END_WORD → DONE.
    - word address == 2**ADDR_W → set ovf_err_o and go to DONE; nothing is written.
    - Otherwise → WRITE.
  - WRITE (1 cycle): imem_csb_o=0, imem_we_o=1, imem_addr_o=addr, imem_wdata_o=word. Then addr+1, byte count cleared, return to COLLECT.
  - DONE: terminal state. Only reset leaves it. Further UART bytes are ignored.
- A byte arriving during CHECK/WRITE is not lost. The receiver needs ≥10 bit-times per byte, so there is no overlap at legal divisors.
- Arbitration:
  - Before DONE the loader owns IMEM: core_gnt_o=0 and core_req_i is ignored.
  - In DONE: imem_csb_o=~core_req_i, imem_we_o=0, imem_addr_o=core_addr_i, core_gnt_o=core_req_i.
  - core_rdata_o=imem_rdata_i always; it is valid per the IMEM one-cycle read latency.
- done_o rises on the cycle the FSM enters DONE. core_rst_no rises exactly 1 cycle after done_o.
- Partial word at END: bytes of an incomplete word are never written. Only full words are checked against END_WORD.
- Reset asserted mid-load aborts immediately:
  - imem_we_o drops on the next cycle.
  - Address and errors clear.
  - A UART frame in flight is discarded; the receiver waits for the next idle→start edge.

Decomposition:
- Package prog_loader_pkg holds:
  - the loader FSM state enum (IDLE, COLLECT, CHECK, WRITE, DONE);
  - the UART receiver state enum (RX_IDLE, RX_START, RX_DATA, RX_STOP);
  - the END_WORD default constant.
- One sub-module, prog_uart_rx: synchroniser, divisor counter and 8N1 deserialiser. Its outputs are byte_valid, byte_data and frame_err.

Test Plan:
- CLKS_PER_BIT=4; send 0x13,0x05,0x00,0x00 then FF,0F,00,00 → one write at addr 0 with data 0x00000513; done_o=1; core_rst_no=1 one cycle later; no errors.
- Load 3 words then END → writes at addr 0,1,2 in order, addr 3 untouched; core_req_i=1 with core_addr_i=1 → imem_addr_o=1, core_gnt_o=1, rdata equals word 1.
- core_req_i held high throughout loading → core_gnt_o=0 and no core-driven IMEM access until done_o.
- Frame with stop bit 0 mid-word → frame_err_o=1, byte dropped, next 4 valid bytes assemble correctly.
- ADDR_W=2; send 5 non-END words → 4 writes (addr 0..3); 5th word sets ovf_err_o, done_o=1, no write.
- Assert wb_rst_i during byte 2 of word 1 → all outputs return to reset values; fresh load from addr 0 completes correctly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state types and constants for the UART program loader
package prog_loader_pkg;
   typedef enum logic [2:0] {IDLE, COLLECT, CHECK, WRITE, DONE} ld_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;
endpackage

// File: rtl/prog_uart_rx.sv
// rtl/prog_uart_rx.sv - 8N1 UART receiver: synchroniser, divisor counter, deserialiser
module prog_uart_rx
   import prog_loader_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   input  logic [DIV_W-1:0] clks_per_bit,
   output logic             byte_valid,
   output logic [7:0]       byte_data,
   output logic             frame_err
);
   rx_state_t        state_q, state_d;
   logic             rx_meta, rx_sync, rx_prev;
   logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_d, ferr_d;
   logic             tick;

   assign tick      = (cnt_q == '0);
   assign byte_data = shift_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         // Sync flops clear low so a line already low at reset release never looks like a start edge.
         rx_meta    <= 1'b0;
         rx_sync    <= 1'b0;
         rx_prev    <= 1'b0;
         state_q    <= RX_IDLE;
         cnt_q      <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_valid <= valid_d;
         frame_err  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (rx_prev && !rx_sync) begin
               state_d = RX_START;
               div_d   = clks_per_bit;
               cnt_d   = (clks_per_bit >> 1) - DIV_W'(1);
            end
         end
         RX_START: begin
            if (!tick) begin
               cnt_d = cnt_q - DIV_W'(1);
            end else if (rx_sync) begin
               state_d = RX_IDLE;
            end else begin
               state_d = RX_DATA;
               cnt_d   = div_q - DIV_W'(1);
               bit_d   = '0;
            end
         end
         RX_DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - DIV_W'(1);
            end else begin
               shift_d = {rx_sync, shift_q[7:1]};
               cnt_d   = div_q - DIV_W'(1);
               if (bit_q == 3'd7) state_d = RX_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (!tick) begin
               cnt_d = cnt_q - DIV_W'(1);
            end else begin
               state_d = RX_IDLE;
               valid_d = rx_sync;
               ferr_d  = !rx_sync;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end
endmodule

// File: rtl/prog_loader_ctrl.sv
// rtl/prog_loader_ctrl.sv - UART boot loader: packs bytes into IMEM words, then hands IMEM to the core
module prog_loader_ctrl
   import prog_loader_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] END_WORD = END_WORD_DEFAULT,
   parameter int          DIV_W    = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              rx_i,
   input  logic [DIV_W-1:0]  clks_per_bit_i,
   input  logic              core_req_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   output logic              core_gnt_o,
   output logic [31:0]       core_rdata_o,
   output logic              imem_csb_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   input  logic [31:0]       imem_rdata_i,
   output logic              core_rst_no,
   output logic              done_o,
   output logic              ovf_err_o,
   output logic              frame_err_o
);
   ld_state_t         state_q, state_d;
   logic [ADDR_W:0]   addr_q, addr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       word_q, word_d;
   logic              done_q, rst_n_q, ovf_q, ovf_d, ferr_q;
   logic              byte_valid, rx_ferr;
   logic [7:0]        byte_data;

   prog_uart_rx #(.DIV_W(DIV_W)) u_rx (
      .clk          (wb_clk_i),
      .rst          (wb_rst_i),
      .rx           (rx_i),
      .clks_per_bit (clks_per_bit_i),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .frame_err    (rx_ferr)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         done_q  <= 1'b0;
         rst_n_q <= 1'b0;
         ovf_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         done_q  <= done_q | (state_d == DONE);
         rst_n_q <= done_q;
         ovf_q   <= ovf_d;
         ferr_q  <= ferr_q | rx_ferr;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, COLLECT: begin
            if (byte_valid) begin
               word_d[{cnt_q, 3'b000} +: 8] = byte_data;
               cnt_d   = cnt_q + 2'd1;
               state_d = (cnt_q == 2'd3) ? CHECK : COLLECT;
            end
         end
         CHECK: begin
            // Address one past the top means the image does not fit.
            if (word_q == END_WORD) begin
               state_d = DONE;
            end else if (addr_q[ADDR_W]) begin
               ovf_d   = 1'b1;
               state_d = DONE;
            end else begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            addr_d  = addr_q + (ADDR_W+1)'(1);
            cnt_d   = '0;
            state_d = COLLECT;
            if (byte_valid) begin
               word_d[7:0] = byte_data;
               cnt_d       = 2'd1;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      core_gnt_o  = 1'b0;
      imem_csb_o  = 1'b1;
      imem_we_o   = 1'b0;
      imem_addr_o = addr_q[ADDR_W-1:0];
      if (state_q == DONE) begin
         core_gnt_o  = core_req_i;
         imem_csb_o  = ~core_req_i;
         imem_addr_o = core_addr_i;
      end else if (state_q == WRITE) begin
         imem_csb_o = 1'b0;
         imem_we_o  = 1'b1;
      end
   end

   assign imem_wdata_o = word_q;
   assign core_rdata_o = imem_rdata_i;
   assign done_o       = done_q;
   assign core_rst_no  = rst_n_q;
   assign ovf_err_o    = ovf_q;
   assign frame_err_o  = ferr_q;
endmodule

// File: tb/tb_prog_loader_ctrl.sv
// tb/tb_prog_loader_ctrl.sv - self-checking bench for prog_loader_ctrl (8-bit and 2-bit address variants)
module tb_prog_loader_ctrl;
   localparam int          CPB   = 4;
   localparam logic [31:0] END_W = 32'h0000_0FFF;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, rx = 1'b1, core_req = 1'b0, mem_clr = 1'b1;
   logic [7:0]  core_addr = 8'd0;
   logic [15:0] cpb = 16'(CPB);

   logic        gnt0, csb0, we0, rstn0, done0, ovf0, ferr0;
   logic [7:0]  addr0;
   logic [31:0] wdata0, rdata0, crdata0;
   logic        gnt2, csb2, we2, rstn2, done2, ovf2, ferr2;
   logic [1:0]  addr2;
   logic [31:0] wdata2, rdata2, crdata2;

   prog_loader_ctrl #(.ADDR_W(8)) dut0 (
      .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx), .clks_per_bit_i(cpb),
      .core_req_i(core_req), .core_addr_i(core_addr), .core_gnt_o(gnt0), .core_rdata_o(crdata0),
      .imem_csb_o(csb0), .imem_we_o(we0), .imem_addr_o(addr0), .imem_wdata_o(wdata0),
      .imem_rdata_i(rdata0), .core_rst_no(rstn0), .done_o(done0), .ovf_err_o(ovf0),
      .frame_err_o(ferr0)
   );

   prog_loader_ctrl #(.ADDR_W(2)) dut2 (
      .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx), .clks_per_bit_i(cpb),
      .core_req_i(core_req), .core_addr_i(core_addr[1:0]), .core_gnt_o(gnt2), .core_rdata_o(crdata2),
      .imem_csb_o(csb2), .imem_we_o(we2), .imem_addr_o(addr2), .imem_wdata_o(wdata2),
      .imem_rdata_i(rdata2), .core_rst_no(rstn2), .done_o(done2), .ovf_err_o(ovf2),
      .frame_err_o(ferr2)
   );

   // IMEM models with one-cycle read latency; untouched words keep a recognisable pattern
   logic [31:0] mem0 [256];
   logic [31:0] mem2 [4];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem0[i] <= 32'hEEEE_0000 + i;
         for (int i = 0; i < 4; i++)   mem2[i] <= 32'hEEEE_0000 + i;
      end else begin
         if (!csb0 && we0)  mem0[addr0] <= wdata0;
         if (!csb0 && !we0) rdata0      <= mem0[addr0];
         if (!csb2 && we2)  mem2[addr2] <= wdata2;
         if (!csb2 && !we2) rdata2      <= mem2[addr2];
      end
   end

   typedef struct packed { logic [7:0] addr; logic [31:0] data; } wr_t;
   wr_t         q0[$], q2[$];
   wr_t         e0, e2, en;
   int          m_n;
   logic [31:0] m_word;
   int          m_addr [2];
   bit          m_done [2], m_ovf [2], m_ferr;
   int          n_chk = 0, n_fail = 0;
   bit          prev_done0, prev_done2;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Word-level model: every 4 good bytes form a word; END stops, a full memory overflows.
   task automatic model_byte(input logic [7:0] b);
      m_word[8*m_n +: 8] = b;
      m_n++;
      if (m_n == 4) begin
         m_n = 0;
         for (int k = 0; k < 2; k++) begin
            if (!m_done[k]) begin
               if (m_word == END_W) begin
                  m_done[k] = 1'b1;
               end else if (m_addr[k] == ((k == 0) ? 256 : 4)) begin
                  m_ovf[k]  = 1'b1;
                  m_done[k] = 1'b1;
               end else begin
                  en.addr = 8'(m_addr[k]);
                  en.data = m_word;
                  if (k == 0) q0.push_back(en);
                  else        q2.push_back(en);
                  m_addr[k]++;
               end
            end
         end
      end
   endtask

   task automatic model_clear();
      q0.delete(); q2.delete();
      m_n = 0; m_word = '0; m_ferr = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_addr[k] = 0; m_done[k] = 1'b0; m_ovf[k] = 1'b0;
      end
   endtask

   task automatic end_checks(input string tag);
      chk({tag, "_pending0"}, q0.size(), 0);
      chk({tag, "_pending2"}, q2.size(), 0);
      chk({tag, "_done0"}, done0, m_done[0]);
      chk({tag, "_ovf0"},  ovf0,  m_ovf[0]);
      chk({tag, "_ferr0"}, ferr0, m_ferr);
      chk({tag, "_done2"}, done2, m_done[1]);
      chk({tag, "_ovf2"},  ovf2,  m_ovf[1]);
      chk({tag, "_ferr2"}, ferr2, m_ferr);
   endtask

   always @(posedge clk) begin
      #2;
      if (rst) begin
         chk("rst_ctl0", {gnt0, csb0, we0, rstn0, done0, ovf0, ferr0}, 7'b0100000);
         chk("rst_ctl2", {gnt2, csb2, we2, rstn2, done2, ovf2, ferr2}, 7'b0100000);
         chk("rst_addr0", addr0, 0);
         chk("rst_addr2", addr2, 0);
         chk("rst_wdata0", wdata0, 0);
      end else begin
         chk("rstn_after_done0", rstn0, prev_done0);
         chk("rstn_after_done2", rstn2, prev_done2);
         if (!done0) chk("loader_owns0", {gnt0, csb0 | we0}, 2'b01);
         else        chk("core_owns0", {gnt0, csb0, we0, addr0}, {core_req, ~core_req, 1'b0, core_addr});
         if (!done2) chk("loader_owns2", {gnt2, csb2 | we2}, 2'b01);
         else        chk("core_owns2", {gnt2, csb2, we2, addr2}, {core_req, ~core_req, 1'b0, core_addr[1:0]});
         chk("rdata_pass0", crdata0, rdata0);
      end
      if (we0) begin
         chk("write_expected0", 32'(q0.size() != 0), 1);
         if (q0.size() != 0) begin
            e0 = q0.pop_front();
            chk("waddr0", addr0, e0.addr);
            chk("wdata0", wdata0, e0.data);
         end
      end
      if (we2) begin
         chk("write_expected2", 32'(q2.size() != 0), 1);
         if (q2.size() != 0) begin
            e2 = q2.pop_front();
            chk("waddr2", addr2, e2.addr);
            chk("wdata2", wdata2, e2.data);
         end
      end
      prev_done0 = done0;
      prev_done2 = done2;
   end

   task automatic send_raw(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      model_byte(b);
      send_raw(b, 1'b1);
   endtask

   task automatic send_bad(input logic [7:0] b);
      m_ferr = 1'b1;
      send_raw(b, 1'b0);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_pending0", q0.size(), 0);
      chk("reset_pending2", q2.size(), 0);
      model_clear();
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: sequence did not complete, %0d checks so far", n_chk);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_clear();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      mem_clr = 1'b0;

      // single word then END
      send_word(32'h0000_0513);
      send_word(END_W);
      repeat (20) @(negedge clk);
      end_checks("t1");
      chk("t1_mem0_0", mem0[0], 32'h0000_0513);
      chk("t1_mem0_1", mem0[1], 32'hEEEE_0001);
      chk("t1_done_rstn", {done0, rstn0, ovf0, ferr0}, 4'b1100);

      // three words with the core requesting throughout, then a core fetch
      do_reset();
      core_req  = 1'b1;
      core_addr = 8'd2;
      send_word(32'h1122_3344);
      send_word(32'hA5A5_5A5A);
      send_word(32'hCAFE_BABE);
      send_word(END_W);
      repeat (20) @(negedge clk);
      end_checks("t2");
      chk("t2_mem0_0", mem0[0], 32'h1122_3344);
      chk("t2_mem0_1", mem0[1], 32'hA5A5_5A5A);
      chk("t2_mem0_2", mem0[2], 32'hCAFE_BABE);
      chk("t2_mem0_3", mem0[3], 32'hEEEE_0003);
      @(negedge clk);
      core_addr = 8'd1;
      @(posedge clk);
      #3;
      chk("t2_fetch_rdata0", crdata0, 32'hA5A5_5A5A);
      chk("t2_fetch_rdata2", crdata2, 32'hA5A5_5A5A);
      chk("t2_fetch_addr_gnt", {addr0, gnt0}, {8'd1, 1'b1});
      @(negedge clk);
      core_req = 1'b0;
      @(posedge clk);
      #3;
      chk("t2_idle_csb_gnt", {csb0, gnt0}, 2'b10);

      // frame error mid-word and a start-bit glitch
      do_reset();
      send_byte(8'h01);
      send_bad(8'h77);
      send_byte(8'h02);
      send_byte(8'h03);
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (12) @(negedge clk);
      send_byte(8'h04);
      send_word(END_W);
      repeat (20) @(negedge clk);
      end_checks("t4");
      chk("t4_mem0_0", mem0[0], 32'h0403_0201);
      chk("t4_ferr", {ferr0, done0}, 2'b11);

      // five words: the 4-deep instance overflows on the fifth
      do_reset();
      for (int i = 0; i < 5; i++) send_word(32'h5000_0000 + i * 32'h0101);
      repeat (20) @(negedge clk);
      end_checks("t5");
      chk("t5_ovf2_done2", {ovf2, done2}, 2'b11);
      chk("t5_ovf0_done0", {ovf0, done0}, 2'b00);
      chk("t5_mem2_3", mem2[3], 32'h5000_0303);
      chk("t5_mem0_4", mem0[4], 32'h5000_0404);

      // reset in the middle of word 1 byte 2, then a fresh load
      do_reset();
      send_word(32'h0101_0101);
      send_byte(8'h22);
      send_byte(8'h33);
      fork
         send_raw(8'hF5, 1'b1);
         begin
            repeat (24) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #3;
            chk("t6_reset_we_drop", {we0, csb0, done0}, 3'b010);
            @(negedge clk);
            @(negedge clk);
            chk("t6_reset_pending0", q0.size(), 0);
            model_clear();
            rst = 1'b0;
         end
      join
      send_word(32'hDEAD_BEEF);
      send_word(32'h00C0_FFEE);
      send_word(END_W);
      repeat (20) @(negedge clk);
      end_checks("t6");
      chk("t6_mem0_0", mem0[0], 32'hDEAD_BEEF);
      chk("t6_mem0_1", mem0[1], 32'h00C0_FFEE);
      chk("t6_flags", {done0, rstn0, ferr0, ovf0}, 4'b1100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
